// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard detection for load-use, MUL/DIV RAW/WAW and MUL/DIV structural conflicts
module hazard_scoreboard #(
    parameter int LOAD_LAT = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ID_VALID,
    input  logic [4:0]  ID_ADDR1,
    input  logic [4:0]  ID_ADDR2,
    input  logic [4:0]  ID_RD,
    input  logic        ID_W_EN,
    input  logic        ID_IS_LOAD,
    input  logic        ID_IS_MULDIV,
    input  logic        FLUSH,
    input  logic        MD_DONE,
    input  logic [4:0]  MD_RD,
    output logic        STALL,
    output logic        MD_BUSY,
    output logic        MD_ERR,
    output logic [15:0] STALL_COUNT
);
    typedef enum logic {MD_IDLE, MD_WAIT} md_state_t;

    md_state_t           state;
    logic [4:0]          md_rd;
    logic [LOAD_LAT-1:0] lp_valid;
    logic [4:0]          lp_rd [LOAD_LAT];

    logic load_hit1, load_hit2;
    logic md_hit1, md_hit2, md_hit_rd;
    logic hazard, issue;

    always_comb begin
        load_hit1 = 1'b0;
        load_hit2 = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (lp_valid[i] && (lp_rd[i] == ID_ADDR1)) load_hit1 = 1'b1;
            if (lp_valid[i] && (lp_rd[i] == ID_ADDR2)) load_hit2 = 1'b1;
        end
        load_hit1 = load_hit1 && (ID_ADDR1 != 5'd0);
        load_hit2 = load_hit2 && (ID_ADDR2 != 5'd0);
    end

    assign md_hit1   = (state == MD_WAIT) && (ID_ADDR1 != 5'd0) && (ID_ADDR1 == md_rd);
    assign md_hit2   = (state == MD_WAIT) && (ID_ADDR2 != 5'd0) && (ID_ADDR2 == md_rd);
    assign md_hit_rd = (state == MD_WAIT) && (ID_RD != 5'd0) && (ID_RD == md_rd);

    // MD_DONE is deliberately absent here: a completing MUL/DIV releases the stall one cycle later.
    assign hazard = load_hit1 || load_hit2 || md_hit1 || md_hit2 ||
                    (ID_W_EN && md_hit_rd) || (ID_IS_MULDIV && (state == MD_WAIT));
    assign STALL   = ID_VALID && !FLUSH && hazard;
    assign issue   = ID_VALID && !STALL && !FLUSH;
    assign MD_BUSY = (state == MD_WAIT);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lp_valid <= '0;
            for (int i = 0; i < LOAD_LAT; i++) lp_rd[i] <= 5'd0;
        end else begin
            lp_valid[0] <= issue && ID_IS_LOAD && ID_W_EN && (ID_RD != 5'd0);
            lp_rd[0]    <= ID_RD;
            for (int i = 1; i < LOAD_LAT; i++) begin
                lp_valid[i] <= lp_valid[i-1];
                lp_rd[i]    <= lp_rd[i-1];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= MD_IDLE;
            md_rd  <= 5'd0;
            MD_ERR <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (MD_DONE) MD_ERR <= 1'b1;
                    if (issue && ID_IS_MULDIV) begin
                        state <= MD_WAIT;
                        md_rd <= ID_RD;
                    end
                end
                MD_WAIT: begin
                    if (MD_DONE) begin
                        if (MD_RD == md_rd) state <= MD_IDLE;
                        else                MD_ERR <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            STALL_COUNT <= 16'd0;
        end else if (STALL && (STALL_COUNT != 16'hFFFF)) begin
            STALL_COUNT <= STALL_COUNT + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed stimulus with a per-register countdown model checked every cycle
module tb_hazard_scoreboard;
    localparam int LOAD_LAT = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ID_VALID, ID_W_EN, ID_IS_LOAD, ID_IS_MULDIV, FLUSH, MD_DONE;
    logic [4:0]  ID_ADDR1, ID_ADDR2, ID_RD, MD_RD;
    logic        STALL, MD_BUSY, MD_ERR;
    logic [15:0] STALL_COUNT;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: cycles of forwarding delay left per register, plus one outstanding MUL/DIV destination.
    int         load_left [32];
    bit         m_pending = 0;
    logic [4:0] m_dest    = 5'd0;
    bit         m_err     = 0;
    int         m_count   = 0;

    hazard_scoreboard #(.LOAD_LAT(LOAD_LAT)) dut (
        .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID), .ID_ADDR1(ID_ADDR1), .ID_ADDR2(ID_ADDR2),
        .ID_RD(ID_RD), .ID_W_EN(ID_W_EN), .ID_IS_LOAD(ID_IS_LOAD), .ID_IS_MULDIV(ID_IS_MULDIV),
        .FLUSH(FLUSH), .MD_DONE(MD_DONE), .MD_RD(MD_RD), .STALL(STALL), .MD_BUSY(MD_BUSY),
        .MD_ERR(MD_ERR), .STALL_COUNT(STALL_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic bit reads_busy(input logic [4:0] a);
        return (a != 5'd0) && ((load_left[a] > 0) || (m_pending && a == m_dest));
    endfunction

    function automatic bit model_stall();
        if (!ID_VALID || FLUSH) return 1'b0;
        if (reads_busy(ID_ADDR1) || reads_busy(ID_ADDR2)) return 1'b1;
        if (ID_W_EN && m_pending && ID_RD != 5'd0 && ID_RD == m_dest) return 1'b1;
        if (ID_IS_MULDIV && m_pending) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            foreach (load_left[r]) load_left[r] = 0;
            m_pending = 0; m_dest = 5'd0; m_err = 0; m_count = 0;
        end else begin
            bit st, iss;
            st  = model_stall();
            iss = ID_VALID && !st && !FLUSH;
            if (st && m_count != 65535) m_count++;
            foreach (load_left[r]) if (load_left[r] > 0) load_left[r]--;
            if (MD_DONE) begin
                if (m_pending && MD_RD == m_dest) m_pending = 0;
                else m_err = 1;
            end
            if (iss && ID_IS_LOAD && ID_W_EN && ID_RD != 5'd0) load_left[ID_RD] = LOAD_LAT;
            if (iss && ID_IS_MULDIV) begin m_pending = 1; m_dest = ID_RD; end
        end
    end

    always @(negedge CLK) begin
        check("stall_model", STALL, model_stall());
        check("busy_model", MD_BUSY, m_pending);
        check("err_model", MD_ERR, m_err);
        check("count_model", STALL_COUNT, m_count);
    end

    task automatic drive(input bit v, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                         input bit wen, input bit ld, input bit md, input bit fl,
                         input bit dn, input logic [4:0] drd);
        ID_VALID = v; ID_ADDR1 = a1; ID_ADDR2 = a2; ID_RD = rd; ID_W_EN = wen;
        ID_IS_LOAD = ld; ID_IS_MULDIV = md; FLUSH = fl; MD_DONE = dn; MD_RD = drd;
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        idle();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_stall", STALL, 0);
        check("rst_busy", MD_BUSY, 0);
        check("rst_err", MD_ERR, 0);
        check("rst_count", STALL_COUNT, 0);
        RESET = 1'b0;
        tick();

        // load-use on x5
        drive(1, 0, 0, 5, 1, 1, 0, 0, 0, 0); check("lu_c0", STALL, 0); tick();
        drive(1, 5, 0, 3, 1, 0, 0, 0, 0, 0); check("lu_c1", STALL, 1); tick();
        check("lu_c2", STALL, 1); tick();
        check("lu_c3", STALL, 0); check("lu_count", STALL_COUNT, 2); tick();
        idle(); tick();

        // x0 never a hazard
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0); check("x0_ld", STALL, 0); tick();
        drive(1, 0, 0, 6, 1, 0, 0, 0, 0, 0); check("x0_c1", STALL, 0); tick();
        check("x0_c2", STALL, 0); tick();
        idle(); tick();

        // DIV x7 then a reader of x7, completion at cycle N
        drive(1, 0, 0, 7, 1, 0, 1, 0, 0, 0); check("div_issue", STALL, 0); tick();
        drive(1, 1, 7, 6, 1, 0, 0, 0, 0, 0); check("div_busy", MD_BUSY, 1); check("div_raw1", STALL, 1); tick();
        check("div_raw2", STALL, 1); tick();
        drive(1, 1, 7, 6, 1, 0, 0, 0, 1, 7); check("div_doneN", STALL, 1); check("div_busyN", MD_BUSY, 1); tick();
        drive(1, 1, 7, 6, 1, 0, 0, 0, 0, 0); check("div_N1", STALL, 0); check("div_busyN1", MD_BUSY, 0);
        check("div_count", STALL_COUNT, 5); tick();
        idle(); tick();

        // structural / WAW with x7 outstanding
        drive(1, 0, 0, 7, 1, 0, 1, 0, 0, 0); tick();
        drive(1, 1, 2, 9, 1, 0, 1, 0, 0, 0); check("struct_mul", STALL, 1); tick();
        drive(1, 1, 2, 7, 1, 0, 0, 0, 0, 0); check("waw_add", STALL, 1); tick();
        drive(1, 1, 2, 7, 0, 0, 0, 0, 0, 0); check("waw_nowen", STALL, 0); tick();
        drive(1, 1, 2, 8, 1, 0, 0, 0, 0, 0); check("indep_add", STALL, 0); tick();
        drive(1, 7, 0, 8, 1, 0, 0, 1, 0, 0); check("flush_raw", STALL, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7); tick();
        idle(); check("struct_busy", MD_BUSY, 0); check("struct_count", STALL_COUNT, 7); check("no_err", MD_ERR, 0);
        tick();

        // spurious MD_DONE and flushed issues
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3); tick();
        idle(); check("err_set", MD_ERR, 1); repeat (3) tick();
        check("err_held", MD_ERR, 1);
        drive(1, 0, 0, 4, 1, 1, 0, 1, 0, 0); check("flush_ld", STALL, 0); tick();
        drive(1, 4, 4, 5, 1, 0, 0, 0, 0, 0); check("flush_x4_c1", STALL, 0); tick();
        check("flush_x4_c2", STALL, 0); tick();
        drive(1, 0, 0, 9, 1, 0, 1, 1, 0, 0); tick();
        idle(); check("flush_md", MD_BUSY, 0); tick();

        // async reset in MD_WAIT with a load in flight
        drive(1, 0, 0, 10, 1, 0, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 11, 1, 1, 0, 0, 0, 0); check("ar_ld", STALL, 0); tick();
        drive(1, 10, 0, 1, 1, 0, 0, 0, 0, 0); check("ar_pre", STALL, 1);
        #1 RESET = 1'b1;
        #1;
        check("ar_stall", STALL, 0); check("ar_busy", MD_BUSY, 0);
        check("ar_count", STALL_COUNT, 0); check("ar_err", MD_ERR, 0);
        tick();
        RESET = 1'b0;
        drive(1, 11, 10, 1, 1, 0, 0, 0, 0, 0); check("ar_after", STALL, 0); tick();
        idle(); tick();

        // saturation of the stall counter
        drive(1, 0, 0, 12, 1, 0, 1, 0, 0, 0); tick();
        drive(1, 12, 0, 1, 1, 0, 0, 0, 0, 0);
        repeat (65540) tick();
        check("sat_count", STALL_COUNT, 16'hFFFF);
        check("sat_stall", STALL, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 12); tick();
        idle(); check("sat_busy", MD_BUSY, 0); check("sat_hold", STALL_COUNT, 16'hFFFF);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 2, meaning the number of cycles after issue until a load result is forwardable (legal range 1..4).
REQ-002 SHALL have the ports below, one per line as name / direction / width / meaning.
- CLK  input  1  sole clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ID_VALID  input  1  instruction present in ID.
- ID_ADDR1  input  5  rs1 of the ID instruction.
- ID_ADDR2  input  5  rs2 of the ID instruction.
- ID_RD  input  5  rd of the ID instruction.
- ID_W_EN  input  1  ID instruction writes rd.
- ID_IS_LOAD  input  1  ID instruction is a load.
- ID_IS_MULDIV  input  1  ID instruction is a multi-cycle MUL/DIV.
- FLUSH  input  1  cancel this cycle's ID issue.
- MD_DONE  input  1  MUL/DIV unit result written back this cycle.
- MD_RD  input  5  rd of the completing MUL/DIV.
- STALL  output  1  hold IF/ID and insert a bubble in EX.
- MD_BUSY  output  1  a MUL/DIV is outstanding.
- MD_ERR  output  1  sticky flag: MD_DONE seen with no matching outstanding MUL/DIV.
- STALL_COUNT  output  16  saturating count of stall cycles.

Function
REQ-003 SHALL define issue = ID_VALID && !STALL && !FLUSH.
REQ-004 SHALL hold a LOAD_LAT-deep shift pipeline of {valid, rd}.
- Each cycle: shift by one; stage 0 loads {issue && ID_IS_LOAD && ID_W_EN && ID_RD!=0, ID_RD}.
- Entries leaving the last stage are discarded.
REQ-005 SHALL compute load_hit(a) = a!=0 and some valid load-pipeline stage has rd==a.
REQ-006 SHALL implement MUL/DIV FSM states MD_IDLE and MD_WAIT, with a registered md_rd.
- MD_IDLE->MD_WAIT: on issue && ID_IS_MULDIV; md_rd<=ID_RD (MD_WAIT is entered even if ID_W_EN=0 or ID_RD=0).
- MD_WAIT->MD_IDLE: on MD_DONE && MD_RD==md_rd.
REQ-007 SHALL compute md_hit(a) = state==MD_WAIT && a!=0 && a==md_rd.
REQ-008 SHALL drive STALL combinationally from registered state only; it is 1 when ID_VALID && !FLUSH and any of:
- load_hit(ID_ADDR1) or load_hit(ID_ADDR2);
- md_hit(ID_ADDR1) or md_hit(ID_ADDR2);
- ID_W_EN && md_hit(ID_RD) (WAW);
- ID_IS_MULDIV && state==MD_WAIT (structural).
REQ-009 SHALL NOT release a stall through MD_DONE in the same cycle; STALL falls in the cycle after the MD_WAIT->MD_IDLE transition.
REQ-010 SHALL never treat register x0 as a hazard source or destination.
REQ-011 SHALL drive MD_BUSY = (state==MD_WAIT).
REQ-012 SHALL set MD_ERR on MD_DONE while in MD_IDLE, or on MD_DONE with MD_RD!=md_rd while in MD_WAIT; in either case the FSM state is unchanged, and MD_ERR is cleared only by RESET.
REQ-013 SHALL increment STALL_COUNT on each rising edge where STALL=1, saturating at 16'hFFFF.
REQ-014 SHALL make FLUSH override all issue side effects: no load-pipeline entry, no FSM transition, and STALL=0 in that cycle.

Reset
REQ-015 SHALL, on RESET assertion, immediately (asynchronously) clear every load-pipeline valid bit, set state=MD_IDLE, md_rd=0, MD_ERR=0, STALL_COUNT=0.
REQ-016 SHALL, as a consequence of REQ-015, drive STALL=0 and MD_BUSY=0 while RESET is high, including reset asserted mid-MD_WAIT or with loads in flight.

Verification
REQ-017 Load-use, LOAD_LAT=2: issue load x5 at cycle 0; ID uses rs1=x5 at cycles 1 and 2 -> STALL=1 at cycles 1 and 2, STALL=0 at cycle 3, STALL_COUNT=2.
REQ-018 x0 immunity: load with rd=x0, then an instruction reading x0 -> STALL=0 throughout.
REQ-019 MUL/DIV wait: issue DIV x7; the next instruction reads x7 -> STALL=1 until MD_DONE with MD_RD=7 at cycle N; STALL=1 at cycle N and STALL=0 at N+1; MD_BUSY falls at N+1.
REQ-020 Structural/WAW, with MD_WAIT on x7:
- a MUL x9 in ID -> STALL=1;
- an ADD x7 in ID -> STALL=1;
- an ADD x8 reading x1,x2 -> STALL=0.
REQ-021 Error/flush:
- MD_DONE with MD_RD=3 in MD_IDLE -> MD_ERR=1, held until RESET;
- FLUSH=1 with a load x4 in ID -> no later stall on x4.
REQ-022 Async reset: assert RESET mid-MD_WAIT with 1 load in flight -> STALL=0, MD_BUSY=0, STALL_COUNT=0 before the next CLK edge.
